// File: rtl/s4ga_pkg.sv
// Shared constants and width helpers for the s4ga_stream LUT-fabric emulator.
package s4ga_pkg;

    localparam int IDX_ZERO = 0;
    localparam int IDX_ONE  = 1;
    localparam int IDX_Q    = 2;
    localparam int IDX_IN0  = 3;

    function automatic int idx_w(input int n, input int i);
        return $clog2(3 + i + n);
    endfunction

    function automatic int idx_segs(input int n, input int i, input int si_w);
        return (idx_w(n, i) + si_w - 1) / si_w;
    endfunction

    function automatic int mask_segs(input int k, input int si_w);
        return ((1 << k) + si_w - 1) / si_w;
    endfunction

    function automatic int ll(input int n, input int k, input int i, input int si_w);
        return k * idx_segs(n, i, si_w) + mask_segs(k, si_w);
    endfunction

endpackage

// File: rtl/s4ga_lut_eval.sv
// Collects the mask beats of one LUT record and selects the LUT output (and its
// lower-half output) with the already-resolved input vector.
module s4ga_lut_eval #(
    parameter int K     = 5,
    parameter int SI_W  = 4,
    parameter int MSEGS = 8,
    parameter int SEG_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             beat_i,
    input  logic [SEG_W-1:0] seg_i,
    input  logic [SI_W-1:0]  si_i,
    input  logic [K-1:0]     ins_i,
    output logic             lut_o,
    output logic             half_o
);
    localparam int MW = MSEGS * SI_W;

    logic [MW-1:0] mask_q;
    logic [MW-1:0] mask_d;
    logic          last;

    assign last   = (seg_i == SEG_W'(MSEGS - 1));
    // Full mask including the beat currently on the bus; meaningful on the last segment.
    assign mask_d = (mask_q << SI_W) | MW'(si_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q <= '0;
        end else if (beat_i) begin
            mask_q <= last ? '0 : mask_d;
        end
    end

    assign lut_o  = mask_d[ins_i];
    assign half_o = mask_d[{1'b0, ins_i[K-2:0]}];

endmodule

// File: rtl/s4ga_stream.sv
// Serially configured K-LUT fabric emulator fed by a valid/ready config stream.
// Optional macro S4GA_DEBUG_EN enables the debug/debug_valid value stream.
module s4ga_stream
    import s4ga_pkg::*;
#(
    parameter int N    = 293,
    parameter int K    = 5,
    parameter int I    = 2,
    parameter int O    = 7,
    parameter int SI_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SI_W-1:0] si,
    input  logic            si_valid,
    output logic            si_ready,
    input  logic            halt,
    input  logic [I-1:0]    inputs,
    output logic [O-1:0]    outputs,
    output logic            frame_done,
    output logic            debug,
    output logic            debug_valid
);
    localparam int ISEGS  = idx_segs(N, I, SI_W);
    localparam int MSEGS  = mask_segs(K, SI_W);
    localparam int IW     = ISEGS * SI_W;
    localparam int MAXSEG = (ISEGS > MSEGS) ? ISEGS : MSEGS;
    localparam int SEG_W  = (MAXSEG > 1) ? $clog2(MAXSEG) : 1;
    localparam int NW     = (N > 1) ? $clog2(N) : 1;
    localparam int KW     = $clog2(K + 1);

    logic [NW-1:0]    n_q;
    logic [KW-1:0]    k_q;
    logic [SEG_W-1:0] seg_q;
    logic [IW-1:0]    idx_q, idx_d;
    logic [K-1:0]     ins_q;
    logic             q_q;
    logic [I-1:0]     in_lat_q;
    logic [N-1:0]     luts_q, luts_d;
    logic [O-1:0]     outputs_q;
    logic             frame_done_q;

    logic         acc, boundary, is_idx, idx_last, mask_last, frame_end;
    logic [I-1:0] in_eff;
    logic         in_bit, lut, half;

    assign boundary  = (n_q == '0) && (k_q == '0) && (seg_q == '0);
    assign si_ready  = !(halt && boundary);
    assign acc       = si_valid && si_ready;
    assign is_idx    = (k_q != KW'(K));
    assign idx_last  = is_idx && (seg_q == SEG_W'(ISEGS - 1));
    assign mask_last = !is_idx && (seg_q == SEG_W'(MSEGS - 1));
    assign frame_end = acc && mask_last && (n_q == NW'(N - 1));
    // The first beat of a frame already sees the freshly latched inputs.
    assign in_eff    = boundary ? inputs : in_lat_q;
    assign idx_d     = (idx_q << SI_W) | IW'(si);
    assign luts_d    = (luts_q << 1) | N'(lut);

    always_comb begin
        int idx_v;
        idx_v  = int'(idx_d);
        in_bit = 1'b0;
        if (idx_v == IDX_ZERO)     in_bit = 1'b0;
        else if (idx_v == IDX_ONE) in_bit = 1'b1;
        else if (idx_v == IDX_Q)   in_bit = q_q;
        for (int j = 0; j < I; j++)
            if (idx_v == IDX_IN0 + j) in_bit = in_eff[j];
        for (int m = 0; m < N; m++)
            if (idx_v == IDX_IN0 + I + m) in_bit = luts_q[m];
    end

    s4ga_lut_eval #(
        .K    (K),
        .SI_W (SI_W),
        .MSEGS(MSEGS),
        .SEG_W(SEG_W)
    ) u_eval (
        .clk_i (clk),
        .rst_ni(rst_n),
        .beat_i(acc && !is_idx),
        .seg_i (seg_q),
        .si_i  (si),
        .ins_i (ins_q),
        .lut_o (lut),
        .half_o(half)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q          <= '0;
            k_q          <= '0;
            seg_q        <= '0;
            idx_q        <= '0;
            ins_q        <= '0;
            q_q          <= 1'b0;
            in_lat_q     <= '0;
            luts_q       <= '0;
            outputs_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if (frame_end) outputs_q <= luts_d[O-1:0];
            if (acc) begin
                if (boundary) in_lat_q <= inputs;
                if (is_idx) begin
                    idx_q <= idx_d;
                    if (idx_last) begin
                        ins_q <= {ins_q[K-2:0], in_bit};
                        k_q   <= k_q + KW'(1);
                        seg_q <= '0;
                    end else begin
                        seg_q <= seg_q + SEG_W'(1);
                    end
                end else if (mask_last) begin
                    luts_q <= luts_d;
                    q_q    <= half;
                    k_q    <= '0;
                    seg_q  <= '0;
                    n_q    <= (n_q == NW'(N - 1)) ? '0 : n_q + NW'(1);
                end else begin
                    seg_q <= seg_q + SEG_W'(1);
                end
            end
        end
    end

    assign outputs    = outputs_q;
    assign frame_done = frame_done_q;

`ifdef S4GA_DEBUG_EN
    logic debug_q, debug_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            debug_q       <= 1'b0;
            debug_valid_q <= 1'b0;
        end else begin
            debug_valid_q <= acc && (idx_last || mask_last);
            debug_q       <= (acc && idx_last)  ? in_bit :
                             (acc && mask_last) ? lut : 1'b0;
        end
    end

    assign debug       = debug_q;
    assign debug_valid = debug_valid_q;
`else
    assign debug       = 1'b0;
    assign debug_valid = 1'b0;
`endif

endmodule

// File: doc/s4ga_stream.md
Name: s4ga_stream

Overview:
- Second-generation serially configured LUT-fabric emulator.
- Consumes a stream of per-LUT config records (K input indices, then a 2**K mask), SI_W bits per accepted beat, and evaluates one K-LUT per record, N LUTs per frame.
- Adds a valid/ready handshake with stalls, a halt-at-frame-boundary control, inputs latched per frame, and frame-done signalling.
- Sits between the chip-level pin wrapper and the serial config source.

Parameters:
- N, 293: LUTs per frame; N >= O.
- K, 5: LUT inputs; K >= 2.
- I, 2: fabric inputs.
- O, 7: fabric outputs; O <= N.
- SI_W, 4: stream beat width; power of 2; log2(SI_W) <= K-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- si  in  SI_W  config beat.
- si_valid  in  1  beat present.
- si_ready  out  1  beat accepted when si_valid && si_ready.
- halt  in  1  stop at next frame boundary.
- inputs  in  I  fabric inputs.
- outputs  out  O  fabric outputs, registered.
- frame_done  out  1  one-cycle pulse when outputs update.
- debug  out  1  evaluated value stream.
- debug_valid  out  1  debug qualifier.

Behaviour:
Widths:
- IDX_W = clog2(3+I+N).
- IDX_SEGS = ceil(IDX_W/SI_W).
- MASK_SEGS = ceil(2**K/SI_W).
- LL = K*IDX_SEGS + MASK_SEGS beats per LUT.
- Each field is sent big-endian, zero-padded at the MSB end to a segment multiple.

Index map:
- 0 -> 0; 1 -> 1; 2 -> q.
- 3..3+I-1 -> in_lat[0..I-1].
- 3+I+m -> luts[m], the output of the LUT completed m+1 records earlier (crosses frames).
- Index >= 3+I+N reads 0.

Record flow:
- Counters n in [0,N), k in [0,K], seg.
- Beats advance only on an accepted beat; with no acceptance, no state changes anywhere.
- k<K: shift index beats in. On the last index segment, resolve the index to bit `in` and shift it into ins; the first input lands in ins[K-1].
- k==K: receive mask beats. On the last mask segment:
  - lut = mask[ins];
  - half = mask[ins[K-2:0]];
  - luts <= {luts[N-2:0], lut};
  - q <= half;
  - k and seg clear;
  - n wraps at N-1.
- Mask segment bits arriving earlier may be captured on the fly; only the result is mandated.

Frame handling:
- in_lat <= inputs on acceptance of the first beat of LUT 0 (n=0,k=0,seg=0). The current beat uses the new value.
- On the last beat of LUT N-1, next cycle: outputs[0] = that LUT's lut; outputs[j] = luts[j] for j<O; frame_done=1 for exactly that cycle.

Handshake:
- si_ready = !(halt && at frame boundary), where boundary means n=0,k=0,seg=0.
- halt mid-frame takes effect only at the boundary.
- halt and si_valid in the same boundary cycle: no acceptance.

Debug:
- debug_valid=1 the cycle after the last beat of an index (debug=in) or of a mask (debug=lut); otherwise debug=0, debug_valid=0.

Reset:
- Reset asserted clears all of: luts, ins, q, in_lat, counters, outputs, frame_done, debug, debug_valid.
- si_ready follows its formula (1 unless halt).
- Reset mid-record discards the partial record; the next accepted beat is LUT 0, index 0, seg 0.

Optional Feature:
- S4GA_DEBUG_EN defined: debug and debug_valid behave as above.
- Undefined: both tied to 0, and their logic is removed.
- No other behaviour changes.

Decomposition:
- s4ga_pkg holds:
  - functions for IDX_W, IDX_SEGS, MASK_SEGS, LL;
  - IDX_ZERO=0, IDX_ONE=1, IDX_Q=2, IDX_IN0=3.
- One sub-module, s4ga_lut_eval:
  - receives mask beats with the seg counter and ins;
  - returns lut and half at the final segment.

Test Plan:
Config: N=5, K=2, I=2, O=3, SI_W=4 (IDX_W=4, LL=3).
1. All records = indices (0,1), mask 4'b0010; 15 beats back-to-back -> frame_done on cycle 16, outputs=3'b111; second frame also yields 3'b111.
2. LUT4 = indices (3,0), mask 4'b1100; others as scenario 1.
   - inputs=2'b01 at the frame's first beat -> outputs[0]=1.
   - Set inputs=2'b00 mid-frame -> no effect this frame; next frame -> outputs[0]=0.
3. Ring: every LUT = indices (5,0), mask 4'b0011 (NOT luts[0]) -> outputs alternate by LUT parity; frame-to-frame outputs[0] toggles (N odd).
4. Scenario 1 with si_valid low for 10 cycles after beat 7 -> identical outputs, frame_done 10 cycles later, no state change while stalled.
5. halt=1 during LUT 2 -> frame completes, then si_ready=0 at the boundary with si_valid=1 held and counters frozen. Release halt -> next beat accepted as LUT 0.
6. Assert rst_n=0 after beat 5 of frame 2 -> outputs=0, frame_done=0 immediately. After release, a full frame of scenario 1 -> outputs=3'b111.
